// File: rtl/jtkcpu_shift16.sv
// jtkcpu_shift16: counted 16-bit shift/rotate sequencer stepping the ALU's single-bit shift ops.
// Define JTKCPU_SHIFT_CLAMP_EN to clamp LSRD/ASRD/ASLD counts above 16 down to 16.
module jtkcpu_shift16 (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [15:0] value,
    input  logic [7:0]  count,
    input  logic [7:0]  cc_in,
    output logic [7:0]  alu_op,
    output logic [15:0] alu_opnd0,
    output logic [7:0]  alu_cc,
    input  logic [15:0] alu_rslt,
    input  logic [7:0]  alu_cc_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] rslt,
    output logic [7:0]  cc_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state, w_state_nx;
    logic [15:0] r_acc, w_acc_nx;
    logic [7:0]  r_cc, w_cc_nx;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic [7:0]  r_opl, w_opl_nx;
    logic        w_supported;
    logic [7:0]  w_count;

    assign w_supported = (op >= 8'hB8) && (op <= 8'hC1);
`ifdef JTKCPU_SHIFT_CLAMP_EN
    // Logical/arithmetic shifts saturate after 16 steps; rotates through carry do not
    logic w_sat;
    assign w_sat   = op inside {8'hB8, 8'hB9, 8'hBC, 8'hBD, 8'hBE, 8'hBF};
    assign w_count = (w_sat && count > 8'd16) ? 8'd16 : count;
`else
    assign w_count = count;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_cc_nx    = r_cc;
        w_cnt_nx   = r_cnt;
        w_opl_nx   = r_opl;
        case (r_state)
            IDLE: if (start) begin
                w_acc_nx   = value;
                w_cc_nx    = cc_in;
                w_opl_nx   = op;
                w_cnt_nx   = w_supported ? w_count : 8'd0;
                w_state_nx = RUN;
            end
            RUN: if (r_cnt == 8'd0) begin
                w_state_nx = DONE;
            end else begin
                w_acc_nx = alu_rslt;
                w_cc_nx  = alu_cc_out;
                w_cnt_nx = r_cnt - 8'd1;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= 16'd0;
            r_cc    <= 8'd0;
            r_cnt   <= 8'd0;
            r_opl   <= 8'd0;
        end else if (cen) begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_cc    <= w_cc_nx;
            r_cnt   <= w_cnt_nx;
            r_opl   <= w_opl_nx;
        end
    end

    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign rslt      = r_acc;
    assign cc_out    = r_cc;
    assign alu_opnd0 = r_acc;
    assign alu_cc    = r_cc;
    assign alu_op    = r_opl;
endmodule

// File: tb/tb_jtkcpu_shift16.sv
// tb_jtkcpu_shift16: directed checks of the shift sequencer against a behavioural single-bit ALU.
module tb_jtkcpu_shift16;
    logic        rst_n = 1'b0, clk = 1'b0, cen = 1'b1, start = 1'b0;
    logic [7:0]  op = 8'h00, count = 8'h00, cc_in = 8'h00;
    logic [15:0] value = 16'h0000;
    logic [7:0]  alu_op, alu_cc, alu_cc_out, cc_out;
    logic [15:0] alu_opnd0, alu_rslt, rslt;
    logic        busy, done;
    int          n_vec = 0, n_err = 0, cyc;

    jtkcpu_shift16 dut (
        .rst_n(rst_n), .clk(clk), .cen(cen), .start(start), .op(op), .value(value),
        .count(count), .cc_in(cc_in), .alu_op(alu_op), .alu_opnd0(alu_opnd0),
        .alu_cc(alu_cc), .alu_rslt(alu_rslt), .alu_cc_out(alu_cc_out), .busy(busy),
        .done(done), .rslt(rslt), .cc_out(cc_out)
    );

    always #5 clk = ~clk;

    // External ALU single-bit shift ops; CC bits: N=3 Z=2 V=1 C=0
    always_comb begin
        alu_rslt   = alu_opnd0;
        alu_cc_out = alu_cc;
        case (alu_op)
            8'hB8, 8'hB9: begin alu_rslt = {1'b0, alu_opnd0[15:1]}; alu_cc_out[0] = alu_opnd0[0]; end
            8'hBA, 8'hBB: begin alu_rslt = {alu_cc[0], alu_opnd0[15:1]}; alu_cc_out[0] = alu_opnd0[0]; end
            8'hBC, 8'hBD: begin alu_rslt = {alu_opnd0[15], alu_opnd0[15:1]}; alu_cc_out[0] = alu_opnd0[0]; end
            8'hBE, 8'hBF: begin
                alu_rslt = {alu_opnd0[14:0], 1'b0};
                alu_cc_out[0] = alu_opnd0[15];
                alu_cc_out[1] = alu_opnd0[15] ^ alu_opnd0[14];
            end
            8'hC0, 8'hC1: begin
                alu_rslt = {alu_opnd0[14:0], alu_cc[0]};
                alu_cc_out[0] = alu_opnd0[15];
                alu_cc_out[1] = alu_opnd0[15] ^ alu_opnd0[14];
            end
            default: ;
        endcase
        if (alu_op >= 8'hB8 && alu_op <= 8'hC1) begin
            alu_cc_out[2] = alu_rslt == 16'd0;
            alu_cc_out[3] = alu_rslt[15];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start in the current cycle (cycle 0) and wait for done, bounded
    task automatic run(input string tag, input logic [7:0] o, input logic [15:0] v,
                       input logic [7:0] n, input logic [7:0] c, input int exp_cyc);
        op = o; value = v; count = n; cc_in = c; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk({tag, " busy c1"}, busy, 1);
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({tag, " done cycle"}, cyc, exp_cyc);
    endtask

    task automatic idle_after(input string tag);
        tick();
        chk({tag, " done drop"}, done, 0);
        chk({tag, " busy drop"}, busy, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rslt", rslt, 0);
        chk("reset cc_out", cc_out, 0);
        chk("reset alu_op", alu_op, 0);
        rst_n = 1'b1;
        tick();

        run("lsrd1", 8'hB8, 16'h8001, 8'd1, 8'h00, 3);
        chk("lsrd1 rslt", rslt, 16'h4000);
        chk("lsrd1 cc", cc_out, 8'h01);
        idle_after("lsrd1");

        run("asld2", 8'hBE, 16'h4000, 8'd2, 8'h00, 4);
        chk("asld2 rslt", rslt, 16'h0000);
        chk("asld2 cc", cc_out, 8'h07);
        idle_after("asld2");

        run("rold17", 8'hC0, 16'h8000, 8'd17, 8'h00, 19);
        chk("rold17 rslt", rslt, 16'h8000);
        chk("rold17 C", cc_out[0], 0);
        idle_after("rold17");

`ifdef JTKCPU_SHIFT_CLAMP_EN
        run("asrd20", 8'hBC, 16'h8000, 8'd20, 8'h00, 18);
`else
        run("asrd20", 8'hBC, 16'h8000, 8'd20, 8'h00, 22);
`endif
        chk("asrd20 rslt", rslt, 16'hFFFF);
        chk("asrd20 C", cc_out[0], 1);
        chk("asrd20 N", cc_out[3], 1);
        idle_after("asrd20");

        run("lsrd0", 8'hB8, 16'h1234, 8'd0, 8'h0F, 2);
        chk("lsrd0 rslt", rslt, 16'h1234);
        chk("lsrd0 cc", cc_out, 8'h0F);
        cen = 1'b0;
        repeat (3) tick();
        chk("cen low done held", done, 1);
        chk("cen low busy held", busy, 1);
        cen = 1'b1;
        idle_after("cen");

        run("unsup", 8'h12, 16'h1234, 8'd5, 8'h0F, 2);
        chk("unsup rslt", rslt, 16'h1234);
        chk("unsup cc", cc_out, 8'h0F);
        idle_after("unsup");

        op = 8'hBA; value = 16'h00F1; count = 8'd10; cc_in = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op = 8'hB8; value = 16'hFFFF; count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignored start op", alu_op, 8'hBA);
        chk("ignored start acc", rslt, 16'h200F);
        tick();
        chk("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        chk("async rslt", rslt, 0);
        chk("async cc_out", cc_out, 0);
        chk("async alu_op", alu_op, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run("post rst", 8'hB8, 16'h8001, 8'd1, 8'h00, 3);
        chk("post rst rslt", rslt, 16'h4000);
        chk("post rst cc", cc_out, 8'h01);
        idle_after("post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
